alu_arbiter: RTL and testbench

//  Shares the single ARM datapath ALU between two requesters (req0: main decode/execute path,
//  req1: address/auxiliary unit). Round-robin grant, valid/ready request handshake, registered

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Registers operands, captures the result and owns the NZCV flags.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req0_setflags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  input  logic             req1_setflags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_overflow_n,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic last_grant;
  logic owner;
  logic sf;
  logic grant;
  logic take;

  // Pick the requester: sole valid one, else the one not served last.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:  grant = ~last_grant;
      req1_valid & ~req0_valid: grant = 1'b1;
      default:                  grant = 1'b0;
    endcase
  end

  // Next-state, handshake readies and response pulses.
  always_comb begin
    state_nx   = state;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          take       = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nx   = EXEC;
        end
      end
      EXEC: state_nx = DONE;
      DONE: begin
        rsp0_valid = ~reset & ~owner;
        rsp1_valid = ~reset & owner;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand latch on accept, result and flag capture in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 3'b000;
      owner      <= 1'b0;
      sf         <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      flags      <= 4'b0000;
    end else begin
      if (take) begin
        alu_a      <= grant ? req1_a : req0_a;
        alu_b      <= grant ? req1_b : req0_b;
        alu_ctrl   <= grant ? req1_ctrl : req0_ctrl;
        sf         <= grant ? req1_setflags
                            : req0_setflags;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        if (sf) begin
          flags[3] <= alu_n;
          flags[2] <= alu_z;
          // C and V only carry meaning for add/sub.
          if (alu_ctrl[2:1] == 2'b00) begin
            flags[1] <= alu_c;
            flags[0] <= ~alu_overflow_n;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
// Vector table plus contention, reset and single-requester sequences.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_ctrl, req1_ctrl;
  logic         req0_setflags, req1_setflags;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic         alu_n, alu_z, alu_c, alu_overflow_n;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_result;
  logic [3:0]   flags;
  logic         busy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_setflags(req1_setflags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .alu_overflow_n(alu_overflow_n),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .flags(flags), .busy(busy)
  );

  // Behavioural shared ALU; logical ops report C=0, V=0.
  logic [W:0] sum;
  logic       ovf;
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        ovf = (alu_a[W-1] == alu_b[W-1]) &&
              (sum[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
        ovf = (alu_a[W-1] != alu_b[W-1]) &&
              (sum[W-1] != alu_a[W-1]);
      end
      3'b100: sum = {1'b0, alu_a & alu_b};
      3'b101: sum = {1'b0, alu_a | alu_b};
      3'b110: sum = {1'b0, alu_a ^ alu_b};
      default: sum = {1'b0, alu_a};
    endcase
  end
  assign alu_result     = sum[W-1:0];
  assign alu_n          = sum[W-1];
  assign alu_z          = (sum[W-1:0] == '0);
  assign alu_c          = alu_ctrl[2] ? 1'b0 : sum[W];
  assign alu_overflow_n = ~ovf;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   c0, c1;
    logic         s0, s1;
    logic         own;
    logic [W-1:0] res;
    logic [3:0]   fl;
  } vec_t;

  vec_t vt [7];

  // One transaction: accept, EXEC, DONE pulse, back to IDLE.
  task automatic run_vec(input vec_t v, input int i);
    logic [W-1:0] ea;
    ea = v.own ? v.a1 : v.a0;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req0_ctrl = v.c0; req0_setflags = v.s0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    req1_ctrl = v.c1; req1_setflags = v.s1;
    #1;
    chk($sformatf("v%0d ready", i),
        {req0_ready, req1_ready}, {~v.own, v.own});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk($sformatf("v%0d exec busy", i), busy, 1);
    chk($sformatf("v%0d exec rsp", i),
        {rsp0_valid, rsp1_valid}, 0);
    chk($sformatf("v%0d alu_a", i), alu_a, ea);
    chk($sformatf("v%0d alu_ctrl", i), alu_ctrl,
        v.own ? v.c1 : v.c0);
    step();
    chk($sformatf("v%0d done rsp", i),
        {rsp0_valid, rsp1_valid}, {~v.own, v.own});
    chk($sformatf("v%0d result", i), rsp_result, v.res);
    chk($sformatf("v%0d flags", i), flags, v.fl);
    chk($sformatf("v%0d alu_a hold", i), alu_a, ea);
    step();
    chk($sformatf("v%0d idle rsp", i),
        {rsp0_valid, rsp1_valid, busy}, 0);
  endtask

  initial begin
    vt[0] = '{1, 0, 32'h7FFFFFFF, 32'h1, 0, 0,
              3'b000, 3'b000, 1, 0, 0,
              32'h80000000, 4'b1001};
    vt[1] = '{0, 1, 0, 0, 32'h5, 32'h5,
              3'b000, 3'b001, 0, 0, 1,
              32'h0, 4'b1001};
    vt[2] = '{1, 0, 32'h80000001, 32'h80000000, 0, 0,
              3'b000, 3'b000, 1, 0, 0,
              32'h1, 4'b0011};
    vt[3] = '{1, 0, 32'hF0000000, 32'h80000000, 0, 0,
              3'b100, 3'b000, 1, 0, 0,
              32'h80000000, 4'b1011};
    vt[4] = '{1, 1, 32'h1, 32'h1, 32'h0F, 32'hF0,
              3'b000, 3'b101, 1, 1, 1,
              32'hFF, 4'b0011};
    vt[5] = '{1, 1, 32'h1, 32'h1, 32'h3, 32'h4,
              3'b001, 3'b000, 1, 1, 0,
              32'h0, 4'b0110};
    vt[6] = '{0, 1, 0, 0, 32'h3, 32'h5,
              3'b000, 3'b001, 0, 1, 1,
              32'hFFFFFFFE, 4'b1000};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '1; req0_b = '1; req0_ctrl = 3'b001;
    req1_a = '1; req1_b = '1; req1_ctrl = 3'b001;
    req0_setflags = 1'b1; req1_setflags = 1'b1;
    step();
    step();
    chk("rst ready", {req0_ready, req1_ready}, 0);
    chk("rst busy", busy, 0);
    chk("rst flags", flags, 0);
    chk("rst result", rsp_result, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_ctrl", alu_ctrl, 0);
    chk("rst rsp", {rsp0_valid, rsp1_valid}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Both requesters held: strict alternation every 3 cycles.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1;
    req0_ctrl = 3'b000; req0_setflags = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h2; req1_b = 32'h2;
    req1_ctrl = 3'b000; req1_setflags = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rr c%0d", c),
          {req0_ready, req1_ready},
          {c % 6 == 0, c % 6 == 3});
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr flags", flags, 0);
    chk("rr last result", rsp_result, 32'h4);

    // Reset in EXEC discards the op.
    req0_valid = 1'b1; req0_a = 32'h7FFFFFFF; req0_b = 32'h1;
    req0_ctrl = 3'b000; req0_setflags = 1'b1;
    step();
    chk("mid busy", busy, 1);
    reset = 1'b1;
    step();
    chk("mid busy0", busy, 0);
    chk("mid rsp", {rsp0_valid, rsp1_valid}, 0);
    chk("mid flags", flags, 0);
    chk("mid result", rsp_result, 0);
    chk("mid ready rst", req0_ready, 0);
    reset = 1'b0;
    #1;
    chk("mid ready post", req0_ready, 1);
    req0_valid = 1'b0;
    step();
    chk("mid no pulse", {rsp0_valid, rsp1_valid, busy}, 0);

    // Lone req1 is served every 3 cycles.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h3; req1_b = 32'h5;
    req1_ctrl = 3'b001; req1_setflags = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("solo ready c%0d", c),
          {req0_ready, req1_ready}, {1'b0, c % 3 == 0});
      chk($sformatf("solo rsp c%0d", c),
          {rsp0_valid, rsp1_valid}, {1'b0, c % 3 == 2});
      if (c % 3 == 2) begin
        chk($sformatf("solo res c%0d", c),
            rsp_result, 32'hFFFFFFFE);
        chk($sformatf("solo flags c%0d", c), flags, 4'b1000);
      end
      step();
    end
    req1_valid = 1'b0;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
